// File: rtl/tdm_demux_4ch_if.sv
// Bundle between a serial TDM source and tdm_demux_4ch: serial sample inputs plus frame/status outputs.
// Carries no logic of its own, so it adds no latency.
// There is no backpressure: the source paces samples with en. TDM_DEMUX_ERRCNT_EN adds err_cnt.
interface tdm_demux_4ch_if #(
  parameter int SLOT_W = 4
);
  logic                  en;
  logic                  din;
  logic                  fsync;
  logic [4*SLOT_W-1:0]   out;
  logic                  out_valid;
  logic                  locked;
  logic                  sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0]            err_cnt;

  modport master (output en, din, fsync, input out, out_valid, locked, sync_err, err_cnt);
  modport slave  (input en, din, fsync, output out, out_valid, locked, sync_err, err_cnt);
`else
  modport master (output en, din, fsync, input out, out_valid, locked, sync_err);
  modport slave  (input en, din, fsync, output out, out_valid, locked, sync_err);
`endif
endinterface

// File: rtl/tdm_demux_4ch.sv
// Splits a serial TDM stream with fsync into four SLOT_W-bit channels, presented as {ch3,ch2,ch1,ch0}. TDM_DEMUX_ERRCNT_EN adds a saturating err_cnt.
// out and out_valid appear one cycle after the frame's last bit is sampled; sync_err and locked appear one cycle after the offending bit.
// There is no backpressure: en qualifies each sample, and all state holds while en=0.
module tdm_demux_4ch #(
  parameter int SLOT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  tdm_demux_4ch_if.slave  bus
);
  localparam int FW = 4 * SLOT_W;
  localparam int CW = $clog2(FW);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   bcnt;
  logic [FW-1:0]   asm_q;
  logic [FW-1:0]   asm_nxt;
  logic [FW-1:0]   out_q;
  logic            vld_q;
  logic            err_q;
  logic            lock_q;
  logic [CW-1:0]   slot;
  logic [CW-1:0]   pos;
  logic [CW-1:0]   widx;
  logic            err_evt;

  // Bits land directly at their MSB-first slot position, so a frame's bits overwrite any leftovers from an aborted frame.
  always_comb begin
    slot    = bcnt / CW'(SLOT_W);
    pos     = bcnt - slot * CW'(SLOT_W);
    widx    = bus.fsync ? CW'(SLOT_W - 1) : slot * CW'(SLOT_W) + CW'(SLOT_W - 1) - pos;
    asm_nxt = asm_q;
    asm_nxt[widx] = bus.din;
    err_evt = bus.en && (state == RUN) && (bus.fsync ? (bcnt != '0) : (bcnt == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HUNT;
      bcnt   <= '0;
      asm_q  <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      err_q <= err_evt;
      if (bus.en) begin
        if (bus.fsync) begin
          asm_q  <= asm_nxt;
          bcnt   <= CW'(1);
          state  <= RUN;
          lock_q <= 1'b1;
        end else if (state == RUN) begin
          if (bcnt == '0) begin
            state  <= HUNT;
            lock_q <= 1'b0;
          end else begin
            asm_q <= asm_nxt;
            if (bcnt == CW'(FW - 1)) begin
              out_q <= asm_nxt;
              vld_q <= 1'b1;
              bcnt  <= '0;
            end else begin
              bcnt <= bcnt + CW'(1);
            end
          end
        end
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;
  assign bus.locked    = lock_q;
  assign bus.sync_err  = err_q;

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (err_evt && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Testbench for tdm_demux_4ch: drives directed and random TDM streams and compares every cycle against a frame-level reference model.
// Outputs are sampled 1ns after each rising edge.
// en gaps are randomized to exercise sample qualification.
module tb_tdm_demux_4ch;
  localparam int W  = 4;
  localparam int FW = 4 * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_demux_4ch_if #(.SLOT_W(W)) bus();
  tdm_demux_4ch #(.SLOT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Reference state: either hunting, or locked with the bits collected since the frame start.
  bit             m_locked;
  bit             m_bits[$];
  logic [FW-1:0]  m_out;
  bit             m_vld;
  bit             m_err;
  int             m_errcnt;

  int cyc = 0;
  int vld_seen, err_seen, last_vld_cyc;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [FW-1:0] assemble();
    logic [FW-1:0] w;
    w = '0;
    for (int i = 0; i < FW; i++) w[(i / W) * W + (W - 1) - (i % W)] = m_bits[i];
    return w;
  endfunction

  function automatic void model_reset();
    m_locked = 0;
    m_bits.delete();
    m_out = '0;
    m_vld = 0;
    m_err = 0;
    m_errcnt = 0;
  endfunction

  function automatic void model_sample(input bit e, input bit d, input bit f);
    m_vld = 0;
    m_err = 0;
    if (!e) return;
    if (f) begin
      if (m_locked && m_bits.size() != 0) m_err = 1;
      m_bits.delete();
      m_bits.push_back(d);
      m_locked = 1;
    end else if (m_locked) begin
      if (m_bits.size() == 0) begin
        m_err = 1;
        m_locked = 0;
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == FW) begin
          m_out = assemble();
          m_vld = 1;
          m_bits.delete();
        end
      end
    end
    if (m_err && m_errcnt < 255) m_errcnt++;
  endfunction

  task automatic step(input bit e, input bit d, input bit f);
    bus.en = e;
    bus.din = d;
    bus.fsync = f;
    @(posedge clk);
    model_sample(e, d, f);
    cyc++;
    #1;
    check_eq("out", 32'(bus.out), 32'(m_out));
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_vld));
    check_eq("locked", 32'(bus.locked), 32'(m_locked));
    check_eq("sync_err", 32'(bus.sync_err), 32'(m_err));
`ifdef TDM_DEMUX_ERRCNT_EN
    check_eq("err_cnt", 32'(bus.err_cnt), 32'(m_errcnt));
`endif
    if (bus.out_valid) begin
      vld_seen++;
      last_vld_cyc = cyc;
    end
    if (bus.sync_err) err_seen++;
  endtask

  task automatic send_frame(input logic [FW-1:0] word, input bit with_fsync, input bit gapped);
    for (int b = 0; b < FW; b++) begin
      step(1'b1, word[(b / W) * W + (W - 1) - (b % W)], with_fsync && (b == 0));
      if (gapped) step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    check_eq("rst_out", 32'(bus.out), 32'h0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_eq("rst_locked", 32'(bus.locked), 32'h0);
    check_eq("rst_sync_err", 32'(bus.sync_err), 32'h0);
`ifdef TDM_DEMUX_ERRCNT_EN
    check_eq("rst_err_cnt", 32'(bus.err_cnt), 32'h0);
`endif
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    int gpos;
    bit e, f;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.din = 1'b0;
    bus.fsync = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_out", 32'(bus.out), 32'h0);
    check_eq("reset_out_valid", 32'(bus.out_valid), 32'h0);
    check_eq("reset_locked", 32'(bus.locked), 32'h0);
    check_eq("reset_sync_err", 32'(bus.sync_err), 32'h0);
    rst = 1'b0;

    // Normal frame
    vld_seen = 0;
    step(1'b1, 1'b1, 1'b1);
    check_eq("locked_after_first_bit", 32'(bus.locked), 32'h1);
    for (int b = 1; b < FW; b++) step(1'b1, 16'h3A5D >> ((b / W) * W + (W - 1) - (b % W)), 1'b0);
    check_eq("normal_out", 32'(bus.out), 32'h3A5D);
    check_eq("normal_valid", 32'(bus.out_valid), 32'h1);
    step(1'b1, 1'b0, 1'b1);
    check_eq("normal_valid_one_cycle", 32'(bus.out_valid), 32'h0);
    for (int b = 1; b < FW; b++) step(1'b1, 1'b0, 1'b0);

    // Back-to-back frames
    vld_seen = 0;
    err_seen = 0;
    send_frame(16'h3A5D, 1'b1, 1'b0);
    c0 = last_vld_cyc;
    send_frame(16'hFFFF, 1'b1, 1'b0);
    check_eq("b2b_valid_count", 32'(vld_seen), 32'd2);
    check_eq("b2b_spacing", 32'(last_vld_cyc - c0), 32'd16);
    check_eq("b2b_out", 32'(bus.out), 32'hFFFF);
    check_eq("b2b_no_sync_err", 32'(err_seen), 32'd0);

    // Early sync at bit 6
    vld_seen = 0;
    err_seen = 0;
    for (int b = 0; b < 6; b++) step(1'b1, 1'($urandom_range(1)), b == 0);
    c0 = cyc + 1;
    send_frame(16'h1234, 1'b1, 1'b0);
    check_eq("early_err_count", 32'(err_seen), 32'd1);
    check_eq("early_valid_count", 32'(vld_seen), 32'd1);
    check_eq("early_out", 32'(bus.out), 32'h1234);
    check_eq("early_latency", 32'(last_vld_cyc - c0), 32'd15);

    // Missed sync
    send_frame(16'hABCD, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_eq("missed_sync_err", 32'(bus.sync_err), 32'h1);
    check_eq("missed_locked", 32'(bus.locked), 32'h0);
    check_eq("missed_out_kept", 32'(bus.out), 32'hABCD);
    vld_seen = 0;
    send_frame(16'h5555, 1'b0, 1'b0);
    check_eq("hunt_ignores_valid", 32'(vld_seen), 32'd0);
    check_eq("hunt_ignores_locked", 32'(bus.locked), 32'h0);

    // Gapped en
    vld_seen = 0;
    send_frame(16'hC0DE, 1'b1, 1'b1);
    check_eq("gapped_out", 32'(bus.out), 32'hC0DE);
    check_eq("gapped_valid_count", 32'(vld_seen), 32'd1);
    check_eq("gapped_valid_timing", 32'(cyc - last_vld_cyc), 32'd1);

    // Mid-frame reset before bit 9
    for (int b = 0; b < 9; b++) step(1'b1, 1'($urandom_range(1)), b == 0);
    pulse_reset();
    send_frame(16'h0F0F, 1'b1, 1'b0);
    check_eq("post_reset_out", 32'(bus.out), 32'h0F0F);

    // 300 early-sync errors
    for (int i = 0; i < 301; i++) step(1'b1, 1'($urandom_range(1)), 1'b1);
`ifdef TDM_DEMUX_ERRCNT_EN
    check_eq("err_cnt_saturated", 32'(bus.err_cnt), 32'd255);
`endif
    pulse_reset();

    // Random stream with occasional sync glitches and en gaps
    gpos = 0;
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(4) != 0);
      f = e && ((gpos == 0) ^ ($urandom_range(49) == 0));
      if (e) gpos = (gpos + 1) % FW;
      step(e, 1'($urandom_range(1)), f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tdm_demux_4ch.md
# tdm_demux_4ch

Four-channel time-division demultiplexer: the receive-side counterpart of the 4:1 selector in the behavioural library. It takes one serial TDM bit stream with a frame-sync marker and splits each frame into four fixed-width slots, one per channel. It presents all four channels as one registered word with a one-cycle valid strobe. It tracks frame alignment with a two-state FSM and flags sync errors.

## Interface
- `SLOT_W`, default 4: bits per slot. Legal range is 1 to 16. A frame is 4*SLOT_W bits.
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  sample qualifier. When 0, `din` and `fsync` are ignored and all internal state holds.
- `din`  in  1  serial TDM data.
- `fsync`  in  1  high for the single bit that is slot 0, bit 0 (the first bit) of a frame.
- `out`  out  4*SLOT_W  completed frame, laid out as {ch3, ch2, ch1, ch0}. ch0 = `out[SLOT_W-1:0]`.
- `out_valid`  out  1  one-cycle pulse when `out` is updated.
- `locked`  out  1  1 while the FSM is in RUN.
- `sync_err`  out  1  one-cycle pulse on an alignment error.

## Operation
- A sample happens only on a rising edge where `en`=1. A bit counter `bcnt` (0 to 4*SLOT_W-1) gives the slot (`bcnt/SLOT_W`) and the bit position.
- Bits are MSB-first within each slot. The first bit of a slot goes to bit SLOT_W-1 of that channel.
- **HUNT** (reset state):
  - Sample with `fsync`=1: capture `din` as bit 0 of the frame, set `bcnt`=1, go to RUN.
  - Sample with `fsync`=0: discard it.
- **RUN**:
  - Sample with `bcnt`≠0 and `fsync`=0: shift `din` into the assembly register and increment `bcnt`.
  - Last bit of a frame (`bcnt`=4*SLOT_W-1): load the full assembled frame into `out`, pulse `out_valid`, wrap `bcnt` to 0.
  - Expected frame start (`bcnt`=0) with `fsync`=1: start the next frame normally.
  - Expected frame start (`bcnt`=0) with `fsync`=0 (missed sync): pulse `sync_err`, discard the bit, go to HUNT. The frame already delivered stands.
  - Sample with `fsync`=1 and `bcnt`≠0 (early sync): pulse `sync_err`, discard the partial frame, take this bit as bit 0 of a new frame (`bcnt`=1), stay in RUN.
- `out` holds its value between frames. It changes only on a frame completion or on reset.
- Reset asserted at any point: every output clears at once, `bcnt` goes to 0, the FSM goes to HUNT, and any partial frame is lost.

## Timing
- Reset values: `out`=0, `out_valid`=0, `locked`=0, `sync_err`=0, `bcnt`=0, assembly register 0. With the macro defined, `err_cnt`=0.
- Latency:
  - `out` and `out_valid` update on the edge that samples the frame's last bit, so they are visible in the following cycle.
  - `sync_err` and `locked` update on the edge that samples the offending bit.
- `out_valid` and `sync_err` are high for exactly one cycle per event. They are never held through cycles where `en`=0.
- Back-to-back frames with `en` held at 1 produce one `out_valid` every 4*SLOT_W cycles. `locked` stays at 1 throughout.
- Sample with `fsync`=1 that is also the last bit of a frame: early sync wins. There is no `out_valid`, `sync_err` pulses, and a new frame starts.
- All outputs are registered and there are no combinational paths from input to output.

## Configuration
- `TDM_DEMUX_ERRCNT_EN` defined: adds output `err_cnt`  out  8  count of `sync_err` pulses. It saturates at 255 and is cleared only by `rst`.
- Not defined: the port does not exist and the counter logic is absent. All other behaviour is identical.

## Test plan
- **Normal frame** (`SLOT_W`=4, `en`=1): `fsync` on the first bit, then slots 0xD, 0x5, 0xA, 0x3 MSB-first.
  - `out`=16'h3A5D.
  - `out_valid` is a one-cycle pulse in the cycle after the 16th bit.
  - `locked`=1 from the cycle after the first bit.
- **Two back-to-back frames**: 0x3A5D then 0xFFFF, with `fsync` on both frame starts.
  - Two `out_valid` pulses exactly 16 cycles apart.
  - `out`=16'hFFFF after the second.
  - `sync_err` never asserts.
- **Early sync**: `fsync` re-asserted at bit 6 of a frame, followed by a full 0x1234 frame.
  - `sync_err` pulses once and there is no `out_valid` for the aborted frame.
  - `out`=16'h1234 exactly 16 cycles after the early `fsync`.
- **Missed sync**: a valid frame, then `fsync`=0 at the next frame start.
  - `sync_err` pulses and `locked` drops to 0.
  - `out` keeps the last frame.
  - Frames without `fsync` are ignored until the next `fsync`.
- **Gapped `en` and mid-frame reset**:
  - Toggle `en` 1/0 every cycle through a 0xC0DE frame: the result is identical to the normal case, with `out_valid` one cycle after the last enabled sample.
  - Pulse `rst` at bit 9 of a frame: all outputs go to 0 immediately and `locked`=0.
- **With `TDM_DEMUX_ERRCNT_EN` defined**: 300 early-sync errors.
  - `err_cnt` reads 1, 2, … and saturates at 255.
  - `rst` returns it to 0.
